// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one single-port data RAM between port A (CPU) and port B.
// Optional build macro DMEM_ARB_STATS_EN adds grant/conflict debug counters.
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int PRIORITY_A   = 1,
  parameter int MAX_WAIT     = 8
) (
  input  logic              clock,
  input  logic              anti_reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_wEn,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  input  logic [DATA_W-1:0] ram_dataOut
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_a_grants,
  output logic [31:0]       stat_b_grants,
  output logic [31:0]       stat_conflicts
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  port_e                   r_last_gnt;
  logic [WAIT_W-1:0]       r_wait_cnt;
  logic [READ_LATENCY-1:0] r_tag_valid;
  logic [READ_LATENCY-1:0] r_tag_port;
  logic                    r_a_rvalid, r_b_rvalid;
  logic [DATA_W-1:0]       r_a_rdata, r_b_rdata;
  logic                    w_a_gnt, w_b_gnt, w_wait_full, w_rd_issue;
  logic                    w_exit_a, w_exit_b;

  assign w_wait_full = (r_wait_cnt == WAIT_W'(MAX_WAIT));

  // Grants are masked during reset so nothing reaches the RAM while it is held.
  // NOTE: every output of a combinational block gets a default first; otherwise a missed branch infers a latch.
  always_comb begin
    w_a_gnt = 1'b0;
    w_b_gnt = 1'b0;
    if (anti_reset) begin
      if (PRIORITY_A != 0) begin
        w_b_gnt = b_req & (~a_req | w_wait_full);
        w_a_gnt = a_req & ~w_b_gnt;
      end else if (a_req & b_req) begin
        w_a_gnt = (r_last_gnt == PORT_B);
        w_b_gnt = (r_last_gnt == PORT_A);
      end else begin
        w_a_gnt = a_req;
        w_b_gnt = b_req;
      end
    end
  end

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  always_comb begin
    ram_wEn    = 1'b0;
    ram_addr   = '0;
    ram_dataIn = '0;
    if (w_a_gnt) begin
      ram_wEn    = a_we;
      ram_addr   = a_addr;
      ram_dataIn = a_wdata;
    end else if (w_b_gnt) begin
      ram_wEn    = b_we;
      ram_addr   = b_addr;
      ram_dataIn = b_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      r_last_gnt <= PORT_B;
      r_wait_cnt <= '0;
    end else begin
      if (w_a_gnt)      r_last_gnt <= PORT_A;
      else if (w_b_gnt) r_last_gnt <= PORT_B;

      if (PRIORITY_A == 0 || !b_req || w_b_gnt) r_wait_cnt <= '0;
      else if (!w_wait_full)                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
    end
  end

  assign w_rd_issue = (w_a_gnt & ~a_we) | (w_b_gnt & ~b_we);
  assign w_exit_a   = r_tag_valid[READ_LATENCY-1] & ~r_tag_port[READ_LATENCY-1];
  assign w_exit_b   = r_tag_valid[READ_LATENCY-1] &  r_tag_port[READ_LATENCY-1];

  // NOTE: the tag pipe is control state and is reset so in-flight reads are dropped; the data regs only need a known value.
  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      r_tag_valid <= '0;
      r_tag_port  <= '0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_tag_valid[0] <= w_rd_issue;
      r_tag_port[0]  <= w_b_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_port[i]  <= r_tag_port[i-1];
      end
      r_a_rvalid <= w_exit_a;
      r_b_rvalid <= w_exit_b;
      if (w_exit_a) r_a_rdata <= ram_dataOut;
      if (w_exit_b) r_b_rdata <= ram_dataOut;
    end
  end

  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = r_a_rdata;
  assign b_rdata  = r_b_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_a, r_stat_b, r_stat_c;

  always_ff @(posedge clock or negedge anti_reset) begin
    if (!anti_reset) begin
      r_stat_a <= '0;
      r_stat_b <= '0;
      r_stat_c <= '0;
    end else begin
      if (w_a_gnt)       r_stat_a <= r_stat_a + 32'd1;
      if (w_b_gnt)       r_stat_b <= r_stat_b + 32'd1;
      if (a_req & b_req) r_stat_c <= r_stat_c + 32'd1;
    end
  end

  assign stat_a_grants  = r_stat_a;
  assign stat_b_grants  = r_stat_b;
  assign stat_conflicts = r_stat_c;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a fixed-priority instance (index 0) and a round-robin
// instance (index 1), each with its own RAM, checked against a transaction-level model.
module tb_dmem_arbiter;
  localparam int AW = 12, DW = 32, RL = 1, MW = 8;

  logic clock = 1'b0;
  logic anti_reset = 1'b0;
  always #10 clock = ~clock;

  // [dut][port], port 0 = A, port 1 = B
  logic          req   [2][2];
  logic          we    [2][2];
  logic [AW-1:0] addr  [2][2];
  logic [DW-1:0] wdata [2][2];
  logic          gnt   [2][2];
  logic          rvalid[2][2];
  logic [DW-1:0] rdata [2][2];
  logic          ram_we  [2];
  logic [AW-1:0] ram_addr[2];
  logic [DW-1:0] ram_din [2];
  logic [DW-1:0] ram_dout[2];
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] st_a[2], st_b[2], st_c[2];
`endif

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .PRIORITY_A(1), .MAX_WAIT(MW)) u_pa (
    .clock(clock), .anti_reset(anti_reset),
    .a_req(req[0][0]), .a_we(we[0][0]), .a_addr(addr[0][0]), .a_wdata(wdata[0][0]),
    .b_req(req[0][1]), .b_we(we[0][1]), .b_addr(addr[0][1]), .b_wdata(wdata[0][1]),
    .a_gnt(gnt[0][0]), .b_gnt(gnt[0][1]), .a_rvalid(rvalid[0][0]), .b_rvalid(rvalid[0][1]),
    .a_rdata(rdata[0][0]), .b_rdata(rdata[0][1]),
    .ram_wEn(ram_we[0]), .ram_addr(ram_addr[0]), .ram_dataIn(ram_din[0]), .ram_dataOut(ram_dout[0])
`ifdef DMEM_ARB_STATS_EN
    , .stat_a_grants(st_a[0]), .stat_b_grants(st_b[0]), .stat_conflicts(st_c[0])
`endif
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(RL), .PRIORITY_A(0), .MAX_WAIT(MW)) u_rr (
    .clock(clock), .anti_reset(anti_reset),
    .a_req(req[1][0]), .a_we(we[1][0]), .a_addr(addr[1][0]), .a_wdata(wdata[1][0]),
    .b_req(req[1][1]), .b_we(we[1][1]), .b_addr(addr[1][1]), .b_wdata(wdata[1][1]),
    .a_gnt(gnt[1][0]), .b_gnt(gnt[1][1]), .a_rvalid(rvalid[1][0]), .b_rvalid(rvalid[1][1]),
    .a_rdata(rdata[1][0]), .b_rdata(rdata[1][1]),
    .ram_wEn(ram_we[1]), .ram_addr(ram_addr[1]), .ram_dataIn(ram_din[1]), .ram_dataOut(ram_dout[1])
`ifdef DMEM_ARB_STATS_EN
    , .stat_a_grants(st_a[1]), .stat_b_grants(st_b[1]), .stat_conflicts(st_c[1])
`endif
  );

  // Synchronous RAM with RL cycles of read latency, one per instance
  for (genvar d = 0; d < 2; d++) begin : g_ram
    logic [DW-1:0] mem  [1 << AW];
    logic [DW-1:0] pipe [RL];
    initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      for (int i = 0; i < RL; i++) pipe[i] = '0;
    end
    always @(posedge clock) begin
      if (ram_we[d]) mem[ram_addr[d]] <= ram_din[d];
      pipe[0] <= mem[ram_addr[d]];
      for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_dout[d] = pipe[RL-1];
  end

  // Reference model: expected memory contents, outstanding reads, fairness state
  typedef struct { int dut; int port; int due; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] smem   [2][1 << AW];
  logic [DW-1:0] exp_rd [2][2];
  bit            exp_gnt[2][2];
  bit            obs_gnt[2][2];
  bit            pending[2][2];
  int            b_denied;      // consecutive cycles B has been refused on the priority instance
  int            last_g[2];     // last granted port on each instance
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    rq.delete();
    b_denied = 0;
    for (int d = 0; d < 2; d++) begin
      last_g[d] = 1;
      for (int p = 0; p < 2; p++) exp_rd[d][p] = '0;
    end
  endtask

  task automatic drive(input int d, input int p, input bit r, input bit w,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    req[d][p] = r; we[d][p] = w; addr[d][p] = a; wdata[d][p] = wd;
  endtask

  task automatic idle_all();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < 2; p++) begin
        drive(d, p, 1'b0, 1'b0, '0, '0);
        pending[d][p] = 1'b0;
      end
  endtask

  // One clock: check at the falling edge, advance the model, return at posedge+1
  task automatic tick();
    @(negedge clock);
    foreach (rq[i]) if (rq[i].due == cyc) exp_rd[rq[i].dut][rq[i].port] = rq[i].data;
    for (int d = 0; d < 2; d++) begin
      bit rv[2];
      int gp;
      exp_gnt[d][0] = 1'b0;
      exp_gnt[d][1] = 1'b0;
      if (anti_reset) begin
        if (d == 0) begin
          exp_gnt[0][1] = req[0][1] && (!req[0][0] || b_denied >= MW);
          exp_gnt[0][0] = req[0][0] && !exp_gnt[0][1];
        end else if (req[1][0] && req[1][1]) begin
          exp_gnt[1][1 - last_g[1]] = 1'b1;
        end else begin
          exp_gnt[1][0] = req[1][0];
          exp_gnt[1][1] = req[1][1];
        end
      end
      for (int p = 0; p < 2; p++) begin
        rv[p] = 1'b0;
        foreach (rq[i]) if (rq[i].dut == d && rq[i].port == p && rq[i].due == cyc) rv[p] = 1'b1;
        check($sformatf("gnt[%0d][%0d]", d, p), 64'(gnt[d][p]), 64'(exp_gnt[d][p]));
        check($sformatf("rvalid[%0d][%0d]", d, p), 64'(rvalid[d][p]), 64'(rv[p]));
        check($sformatf("rdata[%0d][%0d]", d, p), 64'(rdata[d][p]), 64'(exp_rd[d][p]));
        obs_gnt[d][p] = gnt[d][p];
      end
      gp = exp_gnt[d][0] ? 0 : (exp_gnt[d][1] ? 1 : -1);
      check($sformatf("ram_wEn[%0d]", d), 64'(ram_we[d]), 64'(gp >= 0 ? we[d][gp] : 1'b0));
      check($sformatf("ram_addr[%0d]", d), 64'(ram_addr[d]), 64'(gp >= 0 ? addr[d][gp] : '0));
      check($sformatf("ram_dataIn[%0d]", d), 64'(ram_din[d]), 64'(gp >= 0 ? wdata[d][gp] : '0));
    end
    for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= cyc) rq.delete(i);
    if (anti_reset) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          if (exp_gnt[d][p]) begin
            last_g[d] = p;
            if (we[d][p]) smem[d][addr[d][p]] = wdata[d][p];
            else begin
              ret_t t;
              t.dut = d; t.port = p; t.due = cyc + RL + 1; t.data = smem[d][addr[d][p]];
              rq.push_back(t);
            end
          end
        end
      end
      if (req[0][1] && !exp_gnt[0][1]) b_denied = (b_denied < MW) ? b_denied + 1 : MW;
      else b_denied = 0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic assert_reset();
    anti_reset = 1'b0;
    model_clear();
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < (1 << AW); i++) smem[d][i] = '0;
    idle_all();
    assert_reset();

    // Reset held with B requesting: no grant, no RAM write, outputs cleared
    drive(0, 1, 1'b1, 1'b1, 12'h005, 32'h1111_1111);
    drive(1, 1, 1'b1, 1'b1, 12'h005, 32'h1111_1111);
    repeat (2) tick();
    idle_all();
    anti_reset = 1'b1;
    tick();

    // A write 0x010 then A read 0x010 on both instances
    for (int d = 0; d < 2; d++) drive(d, 0, 1'b1, 1'b1, 12'h010, 32'hDEAD_BEEF);
    tick();
    for (int d = 0; d < 2; d++) drive(d, 0, 1'b1, 1'b0, 12'h010, '0);
    tick();
    idle_all();
    repeat (3) tick();
    for (int d = 0; d < 2; d++)
      check($sformatf("a_rdata_after_write[%0d]", d), 64'(rdata[d][0]), 64'h0000_0000_DEAD_BEEF);

    // Priority instance under constant contention: B forced every MAX_WAIT+1 cycles
    drive(0, 0, 1'b1, 1'b0, 12'h010, '0);
    drive(0, 1, 1'b1, 1'b0, 12'h020, '0);
    for (int k = 1; k <= 2 * (MW + 1); k++) begin
      tick();
      check($sformatf("starve_b_gnt k=%0d", k), 64'(obs_gnt[0][1]), 64'(k % (MW + 1) == 0));
    end
    idle_all();
    repeat (3) tick();

    // Round-robin instance: distinct data per port, then reset with reads in flight
    drive(1, 1, 1'b1, 1'b1, 12'h020, 32'h1234_5678);
    tick();
    drive(1, 1, 1'b0, 1'b0, '0, '0);
    drive(1, 0, 1'b1, 1'b0, 12'h010, '0);
    tick();
    drive(1, 0, 1'b0, 1'b0, '0, '0);
    drive(1, 1, 1'b1, 1'b0, 12'h020, '0);
    tick();
    idle_all();
    assert_reset();
    repeat (2) tick();
    anti_reset = 1'b1;
    drive(1, 0, 1'b1, 1'b0, 12'h010, '0);
    drive(1, 1, 1'b1, 1'b0, 12'h020, '0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("rr_a_gnt k=%0d", k), 64'(obs_gnt[1][0]), 64'(k % 2 == 1));
    end
    idle_all();
    repeat (3) tick();
    check("rr_a_rdata", 64'(rdata[1][0]), 64'h0000_0000_DEAD_BEEF);
    check("rr_b_rdata", 64'(rdata[1][1]), 64'h0000_0000_1234_5678);

    // Random traffic; a requester holds its request until granted
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++) begin
          if (!pending[d][p] && ($urandom % 3 == 0)) begin
            drive(d, p, 1'b1, 1'($urandom % 2), AW'($urandom % 16), $urandom);
            pending[d][p] = 1'b1;
          end
        end
      tick();
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (pending[d][p] && exp_gnt[d][p]) begin
            drive(d, p, 1'b0, 1'b0, '0, '0);
            pending[d][p] = 1'b0;
          end
    end
    idle_all();
    repeat (3) tick();

`ifdef DMEM_ARB_STATS_EN
    assert_reset();
    drive(0, 0, 1'b1, 1'b0, 12'h010, '0);
    drive(0, 1, 1'b1, 1'b0, 12'h020, '0);
    tick();
    anti_reset = 1'b1;
    repeat (10) tick();
    idle_all();
    check("stat_conflicts", 64'(st_c[0]), 64'd10);
    check("stat_grant_sum", 64'(st_a[0]) + 64'(st_b[0]), 64'd10);
    repeat (3) tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within its time budget");
    $fatal(1, "timeout");
  end

endmodule
